probador_tx_gen: RTL

//  Synthesizable, self-checking traffic generator/checker for the phy_tx loopback path.

---
 rtl/probador_tx_gen.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/probador_tx_gen.sv
// Loopback traffic generator/checker: drives per-lane sequences into phy_tx after an
// active preamble, then compares recirculated words against independently regenerated ones.
module probador_tx_gen #(
    parameter int              LANES     = 4,
    parameter int              WIDTH     = 8,
    parameter int              SEQ_LEN   = 16,
    parameter int              PRE_CYC   = 2,
    parameter int              TIMEOUT   = 32,
    parameter logic [WIDTH-1:0] LFSR_TAPS = 8'hB8
) (
    input  logic                   clk_f,
    input  logic                   reset,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic [WIDTH-1:0]       seed,
    input  logic [LANES-1:0]       lane_en,
    input  logic                   gap_en,
    input  logic [LANES*WIDTH-1:0] data_ret,
    input  logic [LANES-1:0]       valid_ret,
    output logic [LANES*WIDTH-1:0] data_out,
    output logic [LANES-1:0]       valid_out,
    output logic                   active,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic                   timeout,
    output logic [15:0]            err_count
);
    localparam int CW = $clog2(SEQ_LEN + 1);
    localparam int PW = $clog2(PRE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, PRE, SEND, DRAIN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [PW-1:0]    pre_cnt_reg;
    logic [CW-1:0]    word_cnt_reg;
    logic             phase_reg;
    logic [TW-1:0]    idle_cnt_reg;
    logic [1:0]       mode_reg;
    logic [LANES-1:0] lane_en_reg;
    logic             gap_reg;
    logic [15:0]      err_reg, err_next;
    logic             timeout_reg;

    logic             start_ok;
    logic             tx_adv;
    logic             drain_timeout;
    logic             send_valid;
    logic             last_word;
    logic [LANES-1:0] err_hit;
    logic [LANES-1:0] lane_complete;
    logic [31:0]      hit_sum, err_sum;

    function automatic logic [WIDTH-1:0] next_word(input logic [1:0] m, input logic [WIDTH-1:0] x);
        case (m)
            2'd0:    return x;
            2'd1:    return x + WIDTH'(1);
            2'd2:    return x[0] ? ((x >> 1) ^ LFSR_TAPS) : (x >> 1);
            default: return {x[WIDTH-2:0], x[WIDTH-1]};
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] start_word(input logic [1:0] m, input logic [WIDTH-1:0] sd,
                                                     input int lane);
        logic [WIDTH-1:0] t;
        case (m)
            2'd2: begin
                t = sd ^ WIDTH'(lane);
                return (t == '0) ? WIDTH'(1) : t;
            end
            2'd3:    return WIDTH'(1) << (lane % WIDTH);
            default: return sd + WIDTH'(lane);
        endcase
    endfunction

    assign start_ok   = start && (state_reg == IDLE || state_reg == DONE);
    assign busy       = (state_reg == PRE) || (state_reg == SEND) || (state_reg == DRAIN);
    assign active     = busy;
    assign done       = (state_reg == DONE);
    assign pass       = done && (err_reg == 16'd0) && !timeout_reg;
    assign timeout    = timeout_reg;
    assign err_count  = err_reg;
    assign send_valid = (state_reg == SEND) && !phase_reg;
    assign last_word  = (word_cnt_reg == CW'(SEQ_LEN - 1));

    always_comb begin
        state_next    = state_reg;
        tx_adv        = 1'b0;
        drain_timeout = 1'b0;
        case (state_reg)
            IDLE, DONE: if (start) state_next = PRE;
            PRE:        if (pre_cnt_reg == PW'(PRE_CYC - 1)) state_next = SEND;
            SEND: begin
                if (!phase_reg && last_word)
                    state_next = DRAIN;
                else if (!(gap_reg && !phase_reg))
                    tx_adv = 1'b1;
            end
            DRAIN: begin
                if (&lane_complete) begin
                    state_next = DONE;
                end else if (valid_ret == '0 && idle_cnt_reg == TW'(TIMEOUT - 1)) begin
                    state_next    = DONE;
                    drain_timeout = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Several lanes may mismatch in one cycle; all of them are added before saturating.
    always_comb begin
        hit_sum = 32'd0;
        for (int i = 0; i < LANES; i++)
            hit_sum = hit_sum + 32'(err_hit[i]);
        err_sum  = 32'(err_reg) + hit_sum;
        err_next = (err_sum > 32'h0000_FFFF) ? 16'hFFFF : err_sum[15:0];
    end

    always_ff @(posedge clk_f) begin
        if (reset) begin
            state_reg    <= IDLE;
            pre_cnt_reg  <= '0;
            word_cnt_reg <= '0;
            phase_reg    <= 1'b0;
            idle_cnt_reg <= '0;
            mode_reg     <= '0;
            lane_en_reg  <= '0;
            gap_reg      <= 1'b0;
            err_reg      <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (start_ok) begin
                mode_reg     <= mode;
                lane_en_reg  <= lane_en;
                gap_reg      <= gap_en;
                pre_cnt_reg  <= '0;
                word_cnt_reg <= '0;
                phase_reg    <= 1'b0;
                idle_cnt_reg <= '0;
                err_reg      <= '0;
                timeout_reg  <= 1'b0;
            end else begin
                err_reg <= err_next;
                if (state_reg == PRE)
                    pre_cnt_reg <= pre_cnt_reg + PW'(1);
                if (state_reg == SEND) begin
                    if (tx_adv) begin
                        word_cnt_reg <= word_cnt_reg + CW'(1);
                        phase_reg    <= 1'b0;
                    end else if (gap_reg && !phase_reg) begin
                        phase_reg <= 1'b1;
                    end
                end
                if (state_reg == DRAIN)
                    idle_cnt_reg <= (valid_ret == '0) ? idle_cnt_reg + TW'(1) : '0;
                if (drain_timeout)
                    timeout_reg <= 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [WIDTH-1:0] tx_reg;
        logic [WIDTH-1:0] exp_reg;
        logic [CW-1:0]    rcv_reg;
        logic             chk_en;

        assign chk_en = valid_ret[gi] && lane_en_reg[gi] && busy;
        // Surplus words beyond the run length are errors regardless of content.
        assign err_hit[gi] = chk_en && ((rcv_reg == CW'(SEQ_LEN)) ||
                                        (data_ret[gi*WIDTH +: WIDTH] != exp_reg));
        assign lane_complete[gi] = !lane_en_reg[gi] || (rcv_reg == CW'(SEQ_LEN));
        assign data_out[gi*WIDTH +: WIDTH] = tx_reg;
        assign valid_out[gi] = send_valid && lane_en_reg[gi];

        always_ff @(posedge clk_f) begin
            if (reset) begin
                tx_reg  <= '0;
                exp_reg <= '0;
                rcv_reg <= '0;
            end else if (start_ok) begin
                tx_reg  <= start_word(mode, seed, gi);
                exp_reg <= start_word(mode, seed, gi);
                rcv_reg <= '0;
            end else begin
                if (tx_adv)
                    tx_reg <= next_word(mode_reg, tx_reg);
                if (chk_en) begin
                    exp_reg <= next_word(mode_reg, exp_reg);
                    if (rcv_reg != CW'(SEQ_LEN))
                        rcv_reg <= rcv_reg + CW'(1);
                end
            end
        end
    end

endmodule
